uart_avalon_ctrl: RTL and testbench

Avalon-MM slave controller that sequences one uart_core instance for the bus.
- TX: buffers CPU bytes in a TX FIFO and drives the core's tx_valid/tx_ready handshake.
- RX: captures received bytes into an RX FIFO.
- Also holds the baud divisor, sticky error flags and the interrupt enable/request logic.
- Sits between the system interconnect and uart_core inside the UART slave IP.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_avalon_ctrl_if.sv | 14 +
 rtl/uart_fifo.sv | 51 +++++
 rtl/uart_avalon_ctrl.sv | 101 ++++++++++
 tb/tb_uart_avalon_ctrl.sv | 165 ++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared register-map constants for the UART Avalon controller.
package uart_pkg;

    typedef logic [1:0] reg_addr_t;

    localparam reg_addr_t ADDR_DATA   = 2'd0;
    localparam reg_addr_t ADDR_STATUS = 2'd1;
    localparam reg_addr_t ADDR_BAUD   = 2'd2;
    localparam reg_addr_t ADDR_IRQ_EN = 2'd3;

    localparam int STAT_RX_NONEMPTY = 0;
    localparam int STAT_TX_FULL     = 1;
    localparam int STAT_TX_EMPTY    = 2;
    localparam int STAT_RX_OVERRUN  = 3;
    localparam int STAT_TX_DROP     = 4;

    localparam int IE_RX       = 0;
    localparam int IE_TX_EMPTY = 1;

    localparam logic [15:0] BAUD_DIV_MIN = 16'd4;

endpackage

// File: rtl/uart_avalon_ctrl_if.sv
// Avalon-MM slave bus bundle (no waitrequest, read latency 1).
interface uart_avalon_ctrl_if;
    import uart_pkg::*;

    reg_addr_t   address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (output address, read, write, writedata, input readdata);
    modport slave  (input address, read, write, writedata, output readdata);

endinterface

// File: rtl/uart_fifo.sv
// First-word-fall-through FIFO; push while full is accepted only alongside a pop.
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (level == '0);
    assign full    = (level == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    // Head is forced to zero when empty so the output is defined straight out of reset.
    assign dout    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/uart_avalon_ctrl.sv
// Avalon-MM register front end for uart_core: TX/RX FIFOs, baud divisor, flags and irq.
module uart_avalon_ctrl
    import uart_pkg::*;
#(
    parameter int          TX_DEPTH       = 16,
    parameter int          RX_DEPTH       = 16,
    parameter logic [15:0] BAUD_DIV_RESET = 16'd434
) (
    input  logic                     clk,
    input  logic                     reset,
    uart_avalon_ctrl_if.slave        bus,
    output logic                     irq,
    input  logic                     rx_ready,
    input  logic [7:0]               rx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready,
    output logic [7:0]               tx_data,
    output logic [15:0]              baud_div
);
    localparam int TXL = $clog2(TX_DEPTH) + 1;
    localparam int RXL = $clog2(RX_DEPTH) + 1;

    logic           tx_full, tx_empty, rx_full, rx_empty;
    logic [TXL-1:0] tx_level;
    logic [RXL-1:0] rx_level;
    logic [7:0]     rx_head;
    logic           rx_overrun, tx_drop;
    logic [1:0]     irq_en;
    logic [31:0]    rd_mux;
    logic           wr_en, rd_en, tx_push, tx_pop, rx_pop, stat_wr;
    logic           unused_wdata;

    // A simultaneous read and write is treated as a write only.
    assign wr_en   = bus.write;
    assign rd_en   = bus.read && !bus.write;
    assign tx_push = wr_en && (bus.address == ADDR_DATA);
    assign tx_pop  = tx_valid && tx_ready;
    assign rx_pop  = rd_en && (bus.address == ADDR_DATA) && !rx_empty;
    assign stat_wr = wr_en && (bus.address == ADDR_STATUS);
    assign tx_valid = !tx_empty;
    assign unused_wdata = ^bus.writedata[31:16];

    uart_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .reset(reset), .push(tx_push), .pop(tx_pop),
        .din(bus.writedata[7:0]), .dout(tx_data),
        .full(tx_full), .empty(tx_empty), .level(tx_level)
    );

    uart_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_ready), .pop(rx_pop),
        .din(rx_data), .dout(rx_head),
        .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    always_comb begin
        rd_mux = '0;
        case (bus.address)
            ADDR_DATA:   rd_mux = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
            ADDR_STATUS: begin
                rd_mux[STAT_RX_NONEMPTY] = !rx_empty;
                rd_mux[STAT_TX_FULL]     = tx_full;
                rd_mux[STAT_TX_EMPTY]    = tx_empty;
                rd_mux[STAT_RX_OVERRUN]  = rx_overrun;
                rd_mux[STAT_TX_DROP]     = tx_drop;
                rd_mux[15:8]             = 8'(rx_level);
                rd_mux[23:16]            = 8'(tx_level);
            end
            ADDR_BAUD:   rd_mux = {16'd0, baud_div};
            default:     rd_mux = {30'd0, irq_en};
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.readdata <= '0;
            irq          <= 1'b0;
            baud_div     <= BAUD_DIV_RESET;
            rx_overrun   <= 1'b0;
            tx_drop      <= 1'b0;
            irq_en       <= '0;
        end else begin
            if (rd_en)
                bus.readdata <= rd_mux;
            if (wr_en && bus.address == ADDR_BAUD && bus.writedata[15:0] >= BAUD_DIV_MIN)
                baud_div <= bus.writedata[15:0];
            if (wr_en && bus.address == ADDR_IRQ_EN)
                irq_en <= bus.writedata[1:0];
            // New error events take priority over a same-cycle W1C.
            if (rx_ready && rx_full && !rx_pop)
                rx_overrun <= 1'b1;
            else if (stat_wr && bus.writedata[STAT_RX_OVERRUN])
                rx_overrun <= 1'b0;
            if (tx_push && tx_full && !tx_pop)
                tx_drop <= 1'b1;
            else if (stat_wr && bus.writedata[STAT_TX_DROP])
                tx_drop <= 1'b0;
            irq <= (irq_en[IE_RX] && !rx_empty) || (irq_en[IE_TX_EMPTY] && tx_empty) || rx_overrun;
        end
    end

endmodule

// File: tb/tb_uart_avalon_ctrl.sv
// Directed self-checking bench for uart_avalon_ctrl.
module tb_uart_avalon_ctrl;
    import uart_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        irq, rx_ready, tx_valid, tx_ready;
    logic [7:0]  rx_data, tx_data;
    logic [15:0] baud_div;
    logic [31:0] rd;
    int          n_assert = 0;
    int          n_fail = 0;

    uart_avalon_ctrl_if bus ();

    uart_avalon_ctrl dut (
        .clk(clk), .reset(reset), .bus(bus), .irq(irq),
        .rx_ready(rx_ready), .rx_data(rx_data),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .baud_div(baud_div)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input reg_addr_t a, input logic [31:0] d);
        bus.address = a; bus.writedata = d; bus.write = 1'b1;
        tick();
        bus.write = 1'b0;
    endtask

    task automatic bus_read(input reg_addr_t a, output logic [31:0] d);
        bus.address = a; bus.read = 1'b1;
        tick();
        bus.read = 1'b0;
        d = bus.readdata;
    endtask

    task automatic rx_byte(input logic [7:0] b);
        rx_ready = 1'b1; rx_data = b;
        tick();
        rx_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
        rx_ready = 1'b0; rx_data = '0; tx_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        tick();

        check("rst_readdata", bus.readdata, 32'h0);
        check("rst_irq", {31'd0, irq}, 32'h0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'h0);
        check("rst_tx_data", {24'd0, tx_data}, 32'h0);
        check("rst_baud", {16'd0, baud_div}, 32'd434);
        bus_read(ADDR_STATUS, rd); check("rst_status", rd, 32'h0000_0004);
        bus_read(ADDR_BAUD, rd);   check("rst_baud_rd", rd, 32'd434);

        // TX handshake
        bus_write(ADDR_DATA, 32'h55);
        bus_write(ADDR_DATA, 32'hA3);
        check("tx_valid_2", {31'd0, tx_valid}, 32'h1);
        check("tx_head_55", {24'd0, tx_data}, 32'h55);
        bus_read(ADDR_STATUS, rd); check("tx_level_2", rd, 32'h0002_0000);
        check("tx_hold_55", {24'd0, tx_data}, 32'h55);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("tx_head_a3", {24'd0, tx_data}, 32'hA3);
        check("tx_valid_1", {31'd0, tx_valid}, 32'h1);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("tx_valid_0", {31'd0, tx_valid}, 32'h0);
        bus_read(ADDR_STATUS, rd); check("tx_empty_again", rd, 32'h0000_0004);

        // RX overrun
        for (int i = 0; i <= 16; i++) rx_byte(8'(i));
        bus_read(ADDR_STATUS, rd); check("rx_full_ovr", rd, 32'h0000_100D);
        check("irq_ovr", {31'd0, irq}, 32'h1);
        bus_read(ADDR_DATA, rd); check("rx_pop_0", rd, 32'h100);
        bus_read(ADDR_DATA, rd); check("rx_pop_1", rd, 32'h101);
        bus_write(ADDR_STATUS, 32'h8);
        bus_read(ADDR_STATUS, rd); check("ovr_cleared", rd, 32'h0000_0E05);
        check("irq_ovr_clr", {31'd0, irq}, 32'h0);
        for (int i = 2; i < 16; i++) begin
            bus_read(ADDR_DATA, rd); check("rx_drain", rd, 32'h100 + 32'(i));
        end
        bus_read(ADDR_DATA, rd); check("rx_empty_read", rd, 32'h0);

        // TX full boundary
        for (int i = 0; i < 16; i++) bus_write(ADDR_DATA, 32'hB0 + 32'(i));
        bus_read(ADDR_STATUS, rd); check("tx_full16", rd, 32'h0010_0002);
        tx_ready = 1'b1; bus_write(ADDR_DATA, 32'h77); tx_ready = 1'b0;
        bus_read(ADDR_STATUS, rd); check("tx_pushpop_full", rd, 32'h0010_0002);
        bus_write(ADDR_DATA, 32'h88);
        bus_read(ADDR_STATUS, rd); check("tx_drop_set", rd, 32'h0010_0012);
        for (int i = 1; i < 16; i++) begin
            check("tx_order", {24'd0, tx_data}, 32'hB0 + 32'(i));
            tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        end
        check("tx_last_77", {24'd0, tx_data}, 32'h77);
        tx_ready = 1'b1; tick(); tx_ready = 1'b0;
        check("tx_88_dropped", {31'd0, tx_valid}, 32'h0);
        bus_write(ADDR_STATUS, 32'h10);
        bus_read(ADDR_STATUS, rd); check("drop_cleared", rd, 32'h0000_0004);
        check("irq_none", {31'd0, irq}, 32'h0);

        // Interrupts
        bus_write(ADDR_IRQ_EN, 32'h1);
        tick();
        check("irq_rx_empty", {31'd0, irq}, 32'h0);
        bus_read(ADDR_IRQ_EN, rd); check("irq_en_rd", rd, 32'h1);
        rx_byte(8'h3C);
        check("irq_lag", {31'd0, irq}, 32'h0);
        tick();
        check("irq_rx", {31'd0, irq}, 32'h1);
        bus_read(ADDR_DATA, rd); check("rx_3c", rd, 32'h13C);
        check("irq_hold", {31'd0, irq}, 32'h1);
        tick();
        check("irq_rx_clr", {31'd0, irq}, 32'h0);
        bus_write(ADDR_IRQ_EN, 32'h2);
        tick();
        check("irq_tx_empty", {31'd0, irq}, 32'h1);
        bus_write(ADDR_IRQ_EN, 32'h0);
        tick();
        check("irq_off", {31'd0, irq}, 32'h0);

        // Baud divisor
        bus_write(ADDR_BAUD, 32'd3);  check("baud_reject3", {16'd0, baud_div}, 32'd434);
        bus_write(ADDR_BAUD, 32'd27); check("baud_27", {16'd0, baud_div}, 32'd27);
        bus_write(ADDR_BAUD, 32'd4);  check("baud_min4", {16'd0, baud_div}, 32'd4);
        bus_read(ADDR_BAUD, rd); check("baud_rd4", rd, 32'd4);

        // read+write together: write wins, readdata holds
        bus_read(ADDR_STATUS, rd); check("pre_rw", rd, 32'h0000_0004);
        bus.address = ADDR_BAUD; bus.writedata = 32'd100; bus.read = 1'b1; bus.write = 1'b1;
        tick();
        bus.read = 1'b0; bus.write = 1'b0;
        check("rw_readdata", bus.readdata, 32'h0000_0004);
        check("rw_baud", {16'd0, baud_div}, 32'd100);

        // Reset mid-TX
        for (int i = 0; i < 5; i++) bus_write(ADDR_DATA, 32'h40 + 32'(i));
        check("pre_rst_valid", {31'd0, tx_valid}, 32'h1);
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_mid_valid", {31'd0, tx_valid}, 32'h0);
        check("rst_mid_baud", {16'd0, baud_div}, 32'd434);
        check("rst_mid_data", {24'd0, tx_data}, 32'h0);
        bus_read(ADDR_STATUS, rd); check("rst_mid_status", rd, 32'h0000_0004);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
